// File: rtl/accum_drain_ctrl.sv
// rtl/accum_drain_ctrl.sv - accumulator row drain: round/shift, ReLU, saturate, 2-entry output FIFO; optional ACCUM_DRAIN_SAT_STATS_EN
module accum_drain_ctrl #(
    parameter int SYS_COL    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int ACCUM_ROW  = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH:0]              num_row,
    input  logic [$clog2(ACCUM_ROW)-1:0]     acc_base,
    input  logic [ADDR_WIDTH-1:0]            out_base,
    input  logic [4:0]                       shift,
    input  logic                             relu_en,
    output logic                             acc_rd_en,
    output logic [$clog2(ACCUM_ROW)-1:0]     acc_rd_addr,
    input  logic [SYS_COL*PSUM_WIDTH-1:0]    acc_rd_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SYS_COL*DATA_WIDTH-1:0]    out_data,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    output logic                             busy,
    output logic                             done
`ifdef ACCUM_DRAIN_SAT_STATS_EN
    ,
    output logic [15:0]                      sat_cnt
`endif
);
    localparam int AAW  = $clog2(ACCUM_ROW);
    localparam int PW1  = PSUM_WIDTH + 1;
    localparam int CNTW = ADDR_WIDTH + 1;
    localparam logic signed [PW1-1:0] SAT_MAX = {{(PW1-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW1-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FIN} state_t;

    state_t                         state;
    logic [CNTW-1:0]                num_row_q;
    logic [AAW-1:0]                 acc_base_q;
    logic [ADDR_WIDTH-1:0]          out_base_q;
    logic [4:0]                     shift_q;
    logic                           relu_q;
    logic [CNTW-1:0]                rd_cnt;
    logic [ADDR_WIDTH-1:0]          push_cnt;
    logic                           rd_pending;

    logic [SYS_COL*DATA_WIDTH-1:0]  fifo_data [2];
    logic [ADDR_WIDTH-1:0]          fifo_addr [2];
    logic                           wr_ptr;
    logic                           rd_ptr;
    logic [1:0]                     fifo_count;

    logic                           start_acc;
    logic                           credit_ok;
    logic                           push;
    logic                           pop;
    logic                           flush_done;
    logic signed [PW1-1:0]          lane_r [SYS_COL];
    logic [SYS_COL*DATA_WIDTH-1:0]  proc_data;

    // Rounding shift in one extra bit so the rounding add never overflows, then optional ReLU
    function automatic logic signed [PW1-1:0] round_relu(input logic [PSUM_WIDTH-1:0] x,
                                                         input logic [4:0] sh,
                                                         input logic relu);
        logic signed [PW1-1:0] ext;
        logic signed [PW1-1:0] rnd;
        logic signed [PW1-1:0] r;
        ext = {x[PSUM_WIDTH-1], x};
        rnd = '0;
        if (sh != 5'd0)
            rnd = PW1'(1) << (sh - 5'd1);
        r = (ext + rnd) >>> sh;
        if (relu && r[PW1-1])
            r = '0;
        return r;
    endfunction

    assign start_acc   = (state == S_IDLE) && start;
    assign credit_ok   = ({1'b0, fifo_count} + {2'b00, rd_pending}) < 3'd2;
    assign acc_rd_en   = (state == S_RUN) && (rd_cnt != num_row_q) && credit_ok;
    assign acc_rd_addr = acc_base_q + AAW'(rd_cnt);
    assign push        = rd_pending;
    assign out_valid   = (fifo_count != 2'd0);
    assign pop         = out_valid && out_ready;
    assign out_data    = fifo_data[rd_ptr];
    assign out_addr    = fifo_addr[rd_ptr];
    assign flush_done  = !rd_pending && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    // Per-lane arithmetic on the returning accumulator row, saturated to the output width
    always_comb begin
        proc_data = '0;
        for (int i = 0; i < SYS_COL; i++) begin
            lane_r[i] = round_relu(acc_rd_data[i*PSUM_WIDTH +: PSUM_WIDTH], shift_q, relu_q);
            if (lane_r[i] > SAT_MAX)
                proc_data[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
            else if (lane_r[i] < SAT_MIN)
                proc_data[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
            else
                proc_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_r[i][DATA_WIDTH-1:0];
        end
    end

    // Job control FSM; done and busy are registered and change together on job end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            num_row_q  <= '0;
            acc_base_q <= '0;
            out_base_q <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            rd_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_row_q  <= num_row;
                        acc_base_q <= acc_base;
                        out_base_q <= out_base;
                        shift_q    <= shift;
                        relu_q     <= relu_en;
                        rd_cnt     <= '0;
                        busy       <= 1'b1;
                        state      <= (num_row == '0) ? S_FLUSH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (acc_rd_en) begin
                        rd_cnt <= rd_cnt + CNTW'(1);
                        if ((rd_cnt + CNTW'(1)) == num_row_q)
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (flush_done) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-return tracking: data arrives one cycle after each read strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_pending <= 1'b0;
        else
            rd_pending <= acc_rd_en;
    end

    // Two-entry output FIFO; the processed row is registered straight into it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            push_cnt   <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= proc_data;
                fifo_addr[wr_ptr] <= out_base_q + push_cnt;
                wr_ptr            <= ~wr_ptr;
                push_cnt          <= push_cnt + ADDR_WIDTH'(1);
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (start_acc)
                push_cnt <= '0;
        end
    end

`ifdef ACCUM_DRAIN_SAT_STATS_EN
    localparam int CW = $clog2(SYS_COL + 1);
    logic [CW-1:0] clip_cnt;
    logic [16:0]   sat_sum;

    // Number of lanes in the incoming row that saturation had to clip
    always_comb begin
        clip_cnt = '0;
        for (int i = 0; i < SYS_COL; i++) begin
            if ((lane_r[i] > SAT_MAX) || (lane_r[i] < SAT_MIN))
                clip_cnt = clip_cnt + CW'(1);
        end
    end

    assign sat_sum = {1'b0, sat_cnt} + 17'(clip_cnt);

    // Clipped-lane counter, sticky at its maximum, restarted by each accepted job
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= '0;
        else if (start_acc)
            sat_cnt <= '0;
        else if (push)
            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_accum_drain_ctrl.sv
// tb/tb_accum_drain_ctrl.sv - scoreboard bench for accum_drain_ctrl with randomized jobs
module tb_accum_drain_ctrl;
    localparam int AW = 8;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_row = '0;
    logic [7:0]    acc_base = '0;
    logic [AW-1:0] out_base = '0;
    logic [4:0]    shift = '0;
    logic          relu_en = 1'b0;
    logic          acc_rd_en;
    logic [7:0]    acc_rd_addr;
    logic [127:0]  acc_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_data;
    logic [7:0]    out_addr;
    logic          busy;
    logic          done;
`ifdef ACCUM_DRAIN_SAT_STATS_EN
    logic [15:0]   sat_cnt;
`endif

    logic [127:0]  acc_mem [256];
    exp_t          exp_q [$];
    logic [7:0]    rd_addr_q [$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            issued = 0;
    int            xfered = 0;
    int            ready_mode = 0;
    int            start_cyc = 0;
    int            done_cyc = 0;
    int            last_xfer_cyc = 0;
    bit            done_seen = 0;
    logic          busy_at_done = 1'b0;
    int            exp_sat = 0;

    accum_drain_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_row(num_row), .acc_base(acc_base),
        .out_base(out_base), .shift(shift), .relu_en(relu_en), .acc_rd_en(acc_rd_en),
        .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .busy(busy),
        .done(done)
`ifdef ACCUM_DRAIN_SAT_STATS_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model_lane(input logic [31:0] w, input int sh, input bit relu, output bit clip);
        longint x;
        longint r;
        x = longint'($signed(w));
        if (sh > 0) r = (x + (64'sd1 <<< (sh - 1))) >>> sh;
        else        r = x;
        if (relu && r < 0) r = 0;
        clip = 0;
        if (r > 32767) begin r = 32767; clip = 1; end
        else if (r < -32768) begin r = -32768; clip = 1; end
        return r[15:0];
    endfunction

    // accumulator memory model: one-cycle read latency, junk when not reading
    initial forever begin
        logic       en;
        logic [7:0] a;
        @(posedge clk);
        cyc++;
        en = acc_rd_en;
        a  = acc_rd_addr;
        if (!rst && en) begin issued++; rd_addr_q.push_back(a); end
        if (!rst && out_valid && out_ready) xfered++;
        #1;
        acc_rd_data = en ? acc_mem[a] : {$urandom, $urandom, $urandom, $urandom};
    end

    // sink readiness
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            phase = (phase + 1) % 3;
        end
    end

    // monitor: scoreboard pops, stall stability, credit rule, done capture
    initial begin
        bit          prev_stall;
        logic [63:0] prev_data;
        logic [7:0]  prev_addr;
        exp_t        e;
        prev_stall = 0;
        prev_data  = '0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {out_valid, out_addr, out_data}, {1'b1, prev_addr, prev_data});
                if (acc_rd_en)
                    check("read_credit", 128'(issued - xfered < 2), 128'd1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_row: got addr %0h data %0h, expected no row", out_addr, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("row_data", out_data, e.data);
                        check("row_addr", out_addr, e.addr);
                    end
                    last_xfer_cyc = cyc;
                end
                if (done) begin
                    done_seen    = 1;
                    done_cyc     = cyc;
                    busy_at_done = busy;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_addr  = out_addr;
            end
        end
    end

    task automatic fill_random(input int ab, input int nr);
        for (int k = 0; k < nr; k++)
            for (int l = 0; l < 4; l++) begin
                logic [31:0] v;
                case ($urandom_range(0, 3))
                    0:       v = $urandom;
                    1:       v = 32'($signed($urandom_range(0, 200000)) - 100000);
                    2:       v = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
                    default: v = 32'($signed($urandom_range(0, 140000)) - 70000);
                endcase
                acc_mem[(ab + k) % 256][l*32 +: 32] = v;
            end
    endtask

    task automatic issue_job(input int nr, input int ab, input int ob, input int sh, input bit relu);
        exp_t e;
        bit   clip;
        int   nclip;
        nclip = 0;
        for (int k = 0; k < nr; k++) begin
            for (int l = 0; l < 4; l++) begin
                e.data[l*16 +: 16] = model_lane(acc_mem[(ab + k) % 256][l*32 +: 32], sh, relu, clip);
                if (clip) nclip++;
            end
            e.addr = 8'((ob + k) % 256);
            exp_q.push_back(e);
        end
        exp_sat = (nclip > 65535) ? 65535 : nclip;
        done_seen = 0;
        @(posedge clk);
        #1;
        rd_addr_q.delete();
        start = 1'b1; num_row = 9'(nr); acc_base = 8'(ab); out_base = 8'(ob);
        shift = 5'(sh); relu_en = relu;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
`ifdef ACCUM_DRAIN_SAT_STATS_EN
        check("sat_cleared_on_start", sat_cnt, 16'd0);
`endif
    endtask

    task automatic run_job(input int nr, input int ab, input int ob, input int sh, input bit relu, input bit poke);
        int budget;
        issue_job(nr, ab, ob, sh, relu);
        budget = 60 + 8 * nr;
        for (int k = 0; k < budget && !done_seen; k++) begin
            @(posedge clk);
            if (poke && k == 2) begin
                #1;
                start = 1'b1; num_row = 9'd3; acc_base = 8'($urandom); out_base = 8'($urandom);
                shift = 5'($urandom); relu_en = ~relu;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        if (!done_seen) begin
            check("done_timeout", 128'd0, 128'd1);
        end else begin
            check("done_cycle", 128'(done_cyc), 128'((nr == 0) ? start_cyc + 2 : last_xfer_cyc + 1));
            check("busy_low_at_done", busy_at_done, 1'b0);
            check("rows_all_seen", 128'(exp_q.size()), 128'd0);
            check("read_count", 128'(rd_addr_q.size()), 128'(nr));
`ifdef ACCUM_DRAIN_SAT_STATS_EN
            check("sat_cnt", sat_cnt, 16'(exp_sat));
`endif
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acc_rd_en"}, acc_rd_en, 1'b0);
        check({tag, "_acc_rd_addr"}, acc_rd_addr, 8'd0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_out_addr"}, out_addr, 8'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
`ifdef ACCUM_DRAIN_SAT_STATS_EN
        check({tag, "_sat_cnt"}, sat_cnt, 16'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) acc_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic drain
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < 4; l++)
                acc_mem[r][l*32 +: 32] = 32'((l + 1) * (r + 1));
        ready_mode = 0;
        run_job(4, 0, 0, 0, 0, 0);

        // rounding, ReLU and saturation corners
        acc_mem[10] = {32'h8000_0000, 32'h7FFF_FFFF, 32'd7, -32'sd6};
        run_job(1, 10, 20, 2, 1, 0);
        run_job(1, 10, 21, 2, 0, 0);

        // backpressure 1,0,0 pattern
        fill_random(40, 6);
        ready_mode = 1;
        run_job(6, 40, 100, 4, 0, 0);

        // address wrap-around
        fill_random(254, 4);
        ready_mode = 0;
        run_job(4, 254, 255, 1, 1, 0);
        check("wrap_rd_count", 128'(rd_addr_q.size()), 128'd4);
        if (rd_addr_q.size() == 4) begin
            check("wrap_rd0", rd_addr_q[0], 8'd254);
            check("wrap_rd1", rd_addr_q[1], 8'd255);
            check("wrap_rd2", rd_addr_q[2], 8'd0);
            check("wrap_rd3", rd_addr_q[3], 8'd1);
        end

        // empty job
        run_job(0, 7, 9, 0, 0, 0);

        // start while busy is ignored
        fill_random(60, 7);
        ready_mode = 1;
        run_job(7, 60, 70, 3, 0, 1);

        // reset mid-job
        fill_random(80, 8);
        issue_job(8, 80, 90, 0, 0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issued = 0;
        xfered = 0;
        done_seen = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrst_no_done", 128'(done_seen), 128'd0);
        check("midrst_idle", {busy, out_valid}, 2'b00);

        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            int nr, ab;
            nr = $urandom_range(0, 9);
            ab = $urandom_range(0, 255);
            fill_random(ab, nr);
            ready_mode = $urandom_range(0, 2);
            run_job(nr, ab, $urandom_range(0, 255), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 0);
        end

`ifdef ACCUM_DRAIN_SAT_STATS_EN
        // clipped-lane statistics: 3 rows x 2 clipped lanes, then a fresh job clears it
        for (int r = 0; r < 3; r++)
            acc_mem[120 + r] = {32'd2, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF};
        ready_mode = 0;
        run_job(3, 120, 0, 0, 0, 0);
        check("sat_first_job", sat_cnt, 16'd6);
        run_job(1, 10, 5, 0, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
